// File: rtl/image_framebuffer_loader.sv
// image_framebuffer_loader
// Copies a WIDTH x HEIGHT image from the (externally muxed) image memories into
// a VGA frame buffer, one pixel per cycle, in raster order.
//
// Ports:
//   clk_in       system clock, rising edge
//   reset        synchronous active-high reset
//   start        single-cycle copy request, honoured only while idle
//   opcode       image select, latched on an accepted start
//   op_sel       latched opcode, drives the image mux select
//   img_address  pixel read address into the image memories
//   img_data     muxed pixel, valid RD_LAT cycles after its address
//   x, y         frame buffer column / row
//   colour       pixel colour to write (0 when op_sel == 0)
//   plot         frame buffer write enable
//   busy         copy in progress
//   done         one-cycle pulse after the last plot
module image_framebuffer_loader #(
  parameter int unsigned WIDTH       = 160,
  parameter int unsigned HEIGHT      = 120,
  parameter int unsigned ADDR_BITS   = 15,
  parameter int unsigned COLOUR_BITS = 3,
  parameter int unsigned OP_BITS     = 3,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OP_BITS-1:0]     opcode,
  output logic [OP_BITS-1:0]     op_sel,
  output logic [ADDR_BITS-1:0]   img_address,
  input  logic [COLOUR_BITS-1:0] img_data,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DrainBits = $clog2(RD_LAT + 1);

  localparam logic [7:0]           ColLast   = 8'(WIDTH - 1);
  localparam logic [6:0]           RowLast   = 7'(HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] AddrLast  = ADDR_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [DrainBits-1:0] DrainLast = DrainBits'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e               state_q;
  logic [7:0]           col_q;
  logic [6:0]           row_q;
  logic [DrainBits-1:0] drain_q;

  // Coordinate pipeline matching the memory read latency. The last stage is
  // the output register: it only loads on a valid entry so x/y hold between plots.
  logic [RD_LAT-1:0] pv_q;
  logic [7:0]        pcol_q [RD_LAT];
  logic [6:0]        prow_q [RD_LAT];
  logic [RD_LAT-1:0] in_v;
  logic [7:0]        in_col [RD_LAT];
  logic [6:0]        in_row [RD_LAT];

  logic                   push_v;
  logic [COLOUR_BITS-1:0] colour_hold_q;
  logic [COLOUR_BITS-1:0] colour_now;

  assign push_v = (state_q == StFetch);

  always_comb begin
    in_v      = '0;
    in_v[0]   = push_v;
    in_col[0] = col_q;
    in_row[0] = row_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      in_v[i]   = pv_q[i-1];
      in_col[i] = pcol_q[i-1];
      in_row[i] = prow_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pv_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pcol_q[i] <= '0;
        prow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pv_q[i] <= in_v[i];
        if ((i != int'(RD_LAT) - 1) || in_v[i]) begin
          pcol_q[i] <= in_col[i];
          prow_q[i] <= in_row[i];
        end
      end
    end
  end

  assign plot = pv_q[RD_LAT-1];
  assign x    = pcol_q[RD_LAT-1];
  assign y    = prow_q[RD_LAT-1];

  // Memory data arrives in the same cycle as its plot, so colour is taken
  // straight from img_data while plotting and held from a register otherwise.
  assign colour_now = (op_sel != '0) ? img_data : '0;
  assign colour     = plot ? colour_now : colour_hold_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      colour_hold_q <= '0;
    end else if (plot) begin
      colour_hold_q <= colour_now;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= StIdle;
      op_sel      <= '0;
      img_address <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_sel      <= opcode;
            img_address <= '0;
            col_q       <= '0;
            row_q       <= '0;
            busy        <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          if ((col_q == ColLast) && (row_q == RowLast)) begin
            // Address stays at the final pixel until the next start.
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            img_address <= (img_address == AddrLast) ? '0 : img_address + 1'b1;
            if (col_q == ColLast) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_framebuffer_loader.sv
// Directed bench for image_framebuffer_loader. A behavioural memory returns
// address[2:0] two cycles after the address (registered address + registered
// data). Cycle numbering: the start-accept edge is edge 0; values sampled just
// after edge n belong to cycle n+1.
module tb_image_framebuffer_loader;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [2:0]  op_sel;
  logic [14:0] img_address;
  logic [2:0]  img_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  logic [14:0] addr_q;
  logic [2:0]  data_q;
  logic        hold7;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    addr_q <= img_address;
    data_q <= addr_q[2:0];
  end

  assign img_data = hold7 ? 3'b111 : data_q;

  image_framebuffer_loader dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .op_sel      (op_sel),
    .img_address (img_address),
    .img_data    (img_data),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one copy from an accepted start. abort_cyc > 0 asserts reset in that
  // cycle; restart_cyc > 0 pulses a second start (expected to be ignored).
  task automatic run_copy(input logic [2:0] op, input int abort_cyc,
                          input int restart_cyc, input logic [2:0] restart_op);
    int cyc, pix, dones, done_cyc;
    int m_ctl, m_pix, m_addr, m_op;
    int c5, c01, lastx, lasty, lastc, wrap_a, wrap_b, a159, a160;
    int ex, ey, ec, exp_addr;
    logic exp_busy, exp_plot, exp_done;
    pix = 0; dones = 0; done_cyc = -1;
    m_ctl = 0; m_pix = 0; m_addr = 0; m_op = 0;
    c5 = -1; c01 = -1; lastx = -1; lasty = -1; lastc = -1;
    wrap_a = -1; wrap_b = -1; a159 = -1; a160 = -1;

    start  = 1'b1;
    opcode = op;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (1) begin
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        break;
      end
      exp_busy = (cyc <= 19202);
      exp_plot = (cyc >= 3) && (cyc <= 19202);
      exp_done = (cyc == 19203);
      if (plot !== exp_plot || busy !== exp_busy || done !== exp_done) m_ctl++;
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      exp_addr = (cyc <= 19200) ? cyc - 1 : 19199;
      if (img_address !== 15'(exp_addr)) m_addr++;
      if (op_sel !== op) m_op++;
      if (plot === 1'b1) begin
        ex = pix % 160;
        ey = pix / 160;
        ec = (op != 0) ? pix % 8 : 0;
        if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(ec)) m_pix++;
        if (x == 5 && y == 0) c5 = colour;
        if (x == 159 && y == 0) wrap_a = cyc;
        if (x == 0 && y == 1) begin
          c01    = colour;
          wrap_b = cyc;
        end
        lastx = x;
        lasty = y;
        lastc = colour;
        pix++;
      end
      if (cyc == 160) a159 = img_address;
      if (cyc == 161) a160 = img_address;
      start  = (cyc == restart_cyc);
      opcode = (cyc == restart_cyc) ? restart_op : op;
      if (cyc == abort_cyc) reset = 1'b1;
      if (cyc >= 19210) break;
      @(posedge clk_in);
      #1;
      cyc++;
    end
    start = 1'b0;

    check("ctl_seq", m_ctl, 0);
    check("pix_seq", m_pix, 0);
    check("addr_seq", m_addr, 0);
    check("op_sel_stable", m_op, 0);
    if (abort_cyc == 0 || abort_cyc > 170) begin
      check("row_wrap_gap", wrap_b - wrap_a, 1);
      check("addr_159", a159, 159);
      check("addr_160", a160, 160);
      if (op != 0) begin
        check("colour_x5y0", c5, 5);
        check("colour_x0y1", c01, 0);
      end
    end
    if (abort_cyc == 0) begin
      check("plot_count", pix, 19200);
      check("done_count", dones, 1);
      check("done_cycle", done_cyc, 19203);
      check("last_x", lastx, 159);
      check("last_y", lasty, 119);
      check("last_colour", lastc, (op != 0) ? 7 : 0);
    end else begin
      check("abort_no_done", dones, 0);
      check("abort_plot_count", pix, abort_cyc - 2);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'd0;
    hold7  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      check("idle_plot", plot, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_op_sel", op_sel, 0);
      check("idle_addr", img_address, 0);
    end

    // Full copy; a start in the done cycle must be ignored.
    run_copy(3'd1, 0, 19203, 3'd5);
    check("op_sel_idle_hold", op_sel, 1);

    // Clear screen: memory data forced to 7 must not reach colour.
    hold7 = 1'b1;
    run_copy(3'd0, 0, 0, 3'd0);
    hold7 = 1'b0;

    // Second start mid-copy is ignored.
    run_copy(3'd2, 0, 100, 3'd3);

    // Reset mid-copy, then a fresh copy restarts from pixel 0.
    run_copy(3'd4, 5000, 0, 3'd0);
    check("post_abort_op_sel", op_sel, 0);
    check("post_abort_addr", img_address, 0);
    run_copy(3'd1, 300, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
